// File: rtl/vga_pkg.sv
// vga_pkg: shared phase encoding, coordinate width and default 640x480@60 timing
package vga_pkg;
  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;
  localparam int COORD_W = 11;
  localparam int MAX_LEN = (1 << COORD_W) - 1;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  function automatic bit len_ok(input int n);
    return n >= 1 && n <= MAX_LEN;
  endfunction
endpackage

// File: rtl/vga_axis_seq.sv
// vga_axis_seq: one raster axis walking ACT -> FP -> SYNC -> BP, exposing its post-step phase/count
module vga_axis_seq
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  output phase_t             phase,
  output logic [COORD_W-1:0] count,
  output logic               wrap
);
  phase_t cur_phase;
  logic [COORD_W-1:0] cur_count, last;
  logic at_end;
  // phase/count are the values this axis holds after the current edge, so the top can register outputs with no lag
  always_comb begin
    last = cur_phase == PH_ACT ? COORD_W'(ACTIVE - 1) : cur_phase == PH_FP ? COORD_W'(FP - 1) : cur_phase == PH_SYNC ? COORD_W'(SYNC - 1) : COORD_W'(BP - 1);
    at_end = cur_count == last;
    wrap = step && at_end && cur_phase == PH_BP;
    phase = step && at_end ? phase_t'(cur_phase + 2'd1) : cur_phase;
    count = !step ? cur_count : at_end ? '0 : cur_count + COORD_W'(1);
  end
  // reset parks the axis on the last count of back porch so the first step enters the active region
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_phase <= PH_BP;
      cur_count <= COORD_W'(BP - 1);
    end else begin
      cur_phase <= phase;
      cur_count <= count;
    end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing (sync, display enable, 1-based coordinates, line/frame strobes); VGA_SYNC_ALIGN_EN adds one register stage on oHS/oVS
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP = DEF_H_FP,
  parameter int   H_SYNC = DEF_H_SYNC,
  parameter int   H_BP = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP = DEF_V_FP,
  parameter int   V_SYNC = DEF_V_SYNC,
  parameter int   V_BP = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               VGA_CLK,
  input  logic               RESET,
  input  logic               EN,
  output logic               oHS,
  output logic               oVS,
  output logic               oSYNC_COLOR,
  output logic [COORD_W-1:0] oCurrent_X,
  output logic [COORD_W-1:0] oCurrent_Y,
  output logic               oLINE_START,
  output logic               oFRAME_START
);
  phase_t h_phase, v_phase;
  logic [COORD_W-1:0] h_count, v_count;
  logic h_wrap, v_wrap, hs, vs;
  if (!(len_ok(H_ACTIVE) && len_ok(H_FP) && len_ok(H_SYNC) && len_ok(H_BP) && len_ok(V_ACTIVE) && len_ok(V_FP) && len_ok(V_SYNC) && len_ok(V_BP))) begin : g_bad_timing
    $fatal(1, "vga_timing_ctrl: every timing length must be in 1..%0d", MAX_LEN);
  end
  vga_axis_seq #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(VGA_CLK), .rst_n(RESET), .step(EN), .phase(h_phase), .count(h_count), .wrap(h_wrap)
  );
  vga_axis_seq #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(VGA_CLK), .rst_n(RESET), .step(h_wrap), .phase(v_phase), .count(v_count), .wrap(v_wrap)
  );
  // decode post-edge axis state into registered outputs; strobes only live on enabled edges
  always_ff @(posedge VGA_CLK or negedge RESET)
    if (!RESET) begin
      hs <= !SYNC_POL;
      vs <= !SYNC_POL;
      oSYNC_COLOR <= 1'b0;
      oCurrent_X <= '0;
      oCurrent_Y <= '0;
      oLINE_START <= 1'b0;
      oFRAME_START <= 1'b0;
    end else if (EN) begin
      hs <= h_phase == PH_SYNC ? SYNC_POL : !SYNC_POL;
      vs <= v_phase == PH_SYNC ? SYNC_POL : !SYNC_POL;
      oSYNC_COLOR <= h_phase == PH_ACT && v_phase == PH_ACT;
      oCurrent_X <= h_phase == PH_ACT ? h_count + COORD_W'(1) : '0;
      oCurrent_Y <= v_phase == PH_ACT ? v_count + COORD_W'(1) : '0;
      oLINE_START <= h_wrap && v_phase == PH_ACT;
      oFRAME_START <= v_wrap;
    end else begin
      oLINE_START <= 1'b0;
      oFRAME_START <= 1'b0;
    end
`ifdef VGA_SYNC_ALIGN_EN
  // delay sync one enabled clock to line up with colour registered after the coordinates
  always_ff @(posedge VGA_CLK or negedge RESET)
    if (!RESET) begin
      oHS <= !SYNC_POL;
      oVS <= !SYNC_POL;
    end else if (EN) begin
      oHS <= hs;
      oVS <= vs;
    end
`else
  assign oHS = hs;
  assign oVS = vs;
`endif
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized self-checking bench against a raster-index reference model
module tb_vga_timing_ctrl;
  localparam int HA = 16, HFP = 3, HSY = 5, HBP = 4;
  localparam int VA = 6, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
`ifdef VGA_SYNC_ALIGN_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  logic clk = 0, rst_n = 1, en = 0;
  logic hs, vs, de, ls, fs, hs2, vs2, de2, ls2, fs2;
  logic [10:0] x, y, x2, y2;
  int checks = 0, errors = 0;
  int t;
  logic e_hs, e_vs, e_de, e_ls, e_fs, a_hs, a_vs;
  logic [10:0] e_x, e_y;
  logic [53:0] obs, exp_v;
  assign obs = {hs, vs, de, ls, fs, x, y, hs2, vs2, de2, ls2, fs2, x2, y2};

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b0)) dut (
    .VGA_CLK(clk), .RESET(rst_n), .EN(en), .oHS(hs), .oVS(vs), .oSYNC_COLOR(de),
    .oCurrent_X(x), .oCurrent_Y(y), .oLINE_START(ls), .oFRAME_START(fs)
  );
  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1)) dut_pos (
    .VGA_CLK(clk), .RESET(rst_n), .EN(en), .oHS(hs2), .oVS(vs2), .oSYNC_COLOR(de2),
    .oCurrent_X(x2), .oCurrent_Y(y2), .oLINE_START(ls2), .oFRAME_START(fs2)
  );

  always #5 clk = ~clk;

  task automatic pack();
    logic o_hs, o_vs;
    o_hs = LAG != 0 ? a_hs : e_hs;
    o_vs = LAG != 0 ? a_vs : e_vs;
    exp_v = {o_hs, o_vs, e_de, e_ls, e_fs, e_x, e_y, ~o_hs, ~o_vs, e_de, e_ls, e_fs, e_x, e_y};
  endtask

  task automatic model_reset();
    t = FT - 1;
    {e_hs, e_vs, a_hs, a_vs} = 4'b1111;
    {e_de, e_ls, e_fs} = 3'b000;
    e_x = '0;
    e_y = '0;
    pack();
  endtask

  // t is the enabled-clock index within the frame; pixel (1,1) is t == 0
  task automatic model_step(input logic enable);
    int px, ln;
    if (!enable) begin
      e_ls = 0;
      e_fs = 0;
    end else begin
      a_hs = e_hs;
      a_vs = e_vs;
      t = (t + 1) % FT;
      px = t % HT;
      ln = t / HT;
      e_de = px < HA && ln < VA;
      e_x = px < HA ? 11'(px + 1) : 11'd0;
      e_y = ln < VA ? 11'(ln + 1) : 11'd0;
      e_hs = !(px >= HA + HFP && px < HA + HFP + HSY);
      e_vs = !(ln >= VA + VFP && ln < VA + VFP + VSY);
      e_ls = px == 0 && ln < VA;
      e_fs = t == 0;
    end
    pack();
  endtask

  task automatic cycle(input logic enable);
    @(negedge clk);
    en = enable;
    @(posedge clk);
    model_step(enable);
    #1;
  endtask

  task automatic seek(input int want_x, input int want_y);
    int n = 0;
    while (!(e_x == 11'(want_x) && e_y == 11'(want_y)) && n < 2 * FT) begin
      cycle(1);
      n++;
    end
    checks++;
    if (n >= 2 * FT) begin
      errors++;
      $display("FAIL seek x=%0d y=%0d not reached within %0d clocks", want_x, want_y, n);
    end
  endtask

  task automatic test_reset();
    en = 0;
    #3 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_async got=%h exp=%h", obs, exp_v); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_held got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_first_line();
    int de_cnt = 0;
    cycle(1);
    checks++;
    if ({x, y, de, ls, fs} !== {11'd1, 11'd1, 3'b111}) begin
      errors++;
      $display("FAIL first_edge got x=%0d y=%0d de=%b ls=%b fs=%b exp x=1 y=1 de=1 ls=1 fs=1", x, y, de, ls, fs);
    end
    de_cnt += int'(de);
    for (int i = 1; i < HT; i++) begin
      cycle(1);
      de_cnt += int'(de);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL first_line k=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (de_cnt != HA) begin errors++; $display("FAIL de_width got=%0d exp=%0d", de_cnt, HA); end
  endtask

  task automatic test_line_timing();
    int fall = 0, low = 0, ls1 = 0, ls2 = 0;
    logic prev = hs;
    for (int k = 1; k <= HT + 1; k++) begin
      cycle(1);
      if (prev && !hs && fall == 0) fall = k;
      if (!hs) low++;
      if (ls && ls1 == 0) ls1 = k;
      else if (ls && ls2 == 0) ls2 = k;
      prev = hs;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL line_timing k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    checks++;
    if (fall != HA + HFP + 1 + LAG) begin errors++; $display("FAIL hs_fall got=%0d exp=%0d", fall, HA + HFP + 1 + LAG); end
    checks++;
    if (low != HSY) begin errors++; $display("FAIL hs_width got=%0d exp=%0d", low, HSY); end
    checks++;
    if (ls1 != 1 || ls2 - ls1 != HT) begin errors++; $display("FAIL line_period got first=%0d period=%0d exp first=1 period=%0d", ls1, ls2 - ls1, HT); end
  endtask

  task automatic test_frames();
    int fs1 = 0, fs2 = 0, vfall = 0, vlow = 0, ycnt = 0;
    logic prev = vs;
    for (int k = 1; k <= 2 * FT + 1; k++) begin
      cycle(1);
      if (fs && fs1 == 0) fs1 = k;
      else if (fs && fs2 == 0) fs2 = k;
      if (fs1 != 0 && fs2 == 0) begin
        if (prev && !vs && vfall == 0) vfall = k;
        if (!vs) vlow++;
        if (y != 0) ycnt++;
      end
      prev = vs;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL frames k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    checks++;
    if (fs1 == 0 || fs2 - fs1 != FT) begin errors++; $display("FAIL frame_period got=%0d exp=%0d", fs2 - fs1, FT); end
    checks++;
    if (vfall - fs1 != (VA + VFP) * HT + LAG) begin errors++; $display("FAIL vs_start got=%0d exp=%0d", vfall - fs1, (VA + VFP) * HT + LAG); end
    checks++;
    if (vlow != VSY * HT) begin errors++; $display("FAIL vs_width got=%0d exp=%0d", vlow, VSY * HT); end
    checks++;
    if (ycnt != VA * HT) begin errors++; $display("FAIL y_nonzero got=%0d exp=%0d", ycnt, VA * HT); end
  endtask

  task automatic test_freeze();
    int enabled = 0, n = 0;
    while (!e_fs && n < 2 * FT) begin cycle(1); n++; end
    while (!(e_x == 11'd12 && e_y == 11'd3) && n < 4 * FT) begin cycle(1); enabled++; n++; end
    for (int i = 0; i < 37; i++) begin
      cycle(0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL freeze i=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (x !== 11'd12 || ls !== 1'b0 || fs !== 1'b0) begin errors++; $display("FAIL freeze_hold got x=%0d ls=%b fs=%b exp x=12 ls=0 fs=0", x, ls, fs); end
    cycle(1);
    enabled++;
    checks++;
    if (x !== 11'd13 || y !== 11'd3) begin errors++; $display("FAIL freeze_resume got x=%0d y=%0d exp x=13 y=3", x, y); end
    while (!fs && n < 4 * FT) begin
      cycle(1);
      enabled++;
      n++;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL freeze_run got=%h exp=%h", obs, exp_v); end
    end
    checks++;
    if (enabled != FT) begin errors++; $display("FAIL freeze_frame_len got=%0d exp=%0d", enabled, FT); end
  endtask

  task automatic test_mid_reset();
    seek(10, 4);
    @(negedge clk);
    en = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_reset got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1;
    cycle(1);
    checks++;
    if ({x, y, fs, ls} !== {11'd1, 11'd1, 2'b11}) begin errors++; $display("FAIL mid_reset_restart got x=%0d y=%0d fs=%b ls=%b exp x=1 y=1 fs=1 ls=1", x, y, fs, ls); end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 900; i++) begin
      cycle($urandom_range(0, 3) != 0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_en i=%0d got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_line_timing();
    test_frames();
    test_freeze();
    test_mid_reset();
    test_random_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Generates raster timing for the VGA output stage: horizontal/vertical sync, display-enable (SYNC_COLOR) and 1-based pixel coordinates.
- Coordinates are 0 outside the visible area, so the downstream colour register blanks on its own.
- Two chained phase state machines (horizontal steps every pixel clock, vertical steps at each line end) plus line/frame start strobes for the pixel source.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low pulses)

Ports:
VGA_CLK  input  1  pixel clock
RESET  input  1  asynchronous reset, active-low
EN  input  1  advance timing when 1; freeze when 0
oHS  output  1  horizontal sync
oVS  output  1  vertical sync
oSYNC_COLOR  output  1  display enable, 1 only inside the active area
oCurrent_X  output  11  pixel column, 1..H_ACTIVE when active, else 0
oCurrent_Y  output  11  pixel row, 1..V_ACTIVE on active lines, else 0
oLINE_START  output  1  one-clock pulse on the first active pixel of each line
oFRAME_START  output  1  one-clock pulse on pixel (1,1) of each frame

Behaviour:
- All outputs are registers on VGA_CLK. RESET low (asynchronous) forces:
  - oHS = oVS = !SYNC_POL; oSYNC_COLOR = 0; oCurrent_X = oCurrent_Y = 0; both strobes = 0.
  - Horizontal FSM to PH_BP with count = H_BP-1; vertical FSM to PH_BP with count = V_BP-1, i.e. the last clock of the frame.
- Horizontal FSM: PH_ACT(H_ACTIVE) -> PH_FP(H_FP) -> PH_SYNC(H_SYNC) -> PH_BP(H_BP) -> PH_ACT.
  - Phase counter counts 0..len-1 and moves on at len-1.
  - H_TOTAL = 800 by default.
- Vertical FSM: same four phases with V_* lengths, counted in lines.
  - Steps only on the clock where the horizontal FSM wraps PH_BP -> PH_ACT.
  - V_TOTAL = 525 by default.
- Outputs reflect the post-edge state on the same edge, with no extra latency.
  - oSYNC_COLOR = (h phase PH_ACT) && (v phase PH_ACT).
  - oCurrent_X = h count+1 in PH_ACT, else 0.
  - oCurrent_Y = v count+1 in v PH_ACT, else 0. It is held for the whole line, including blanking.
  - oHS = SYNC_POL in h PH_SYNC, else !SYNC_POL. oVS likewise for v PH_SYNC.
- First enabled edge after reset release presents X=1, Y=1, oSYNC_COLOR=1, oFRAME_START=1, oLINE_START=1.
- oLINE_START pulses on entry to h PH_ACT only when the v phase is PH_ACT. oFRAME_START is additionally gated by v count 0.
- EN=0: counters, phases and all level outputs hold their values; strobes are forced to 0. The strobes resume on the next enabled edge, with no skipped or duplicated pixel.
- Reset asserted mid-frame: outputs clear immediately; timing restarts as above.
- Widths: each phase length must be 1..2047 and H_ACTIVE/V_ACTIVE ≤ 2047. These are checked at elaboration (fatal on violation). Counters are 11-bit, with no wrap inside a phase.

Optional Feature:
VGA_SYNC_ALIGN_EN
- Defined: oHS and oVS pass through one additional register stage (reset value !SYNC_POL), so sync aligns with colour data that the output stage registers one clock after oSYNC_COLOR/coordinates.
- Not defined: oHS/oVS are updated on the same edge as oSYNC_COLOR.
- Freeze-on-EN=0 applies to the extra stage as well.

Decomposition:
- Package vga_pkg:
  - typedef enum logic [1:0] phase_t {PH_ACT, PH_FP, PH_SYNC, PH_BP};
  - COORD_W = 11;
  - default 640x480@60 timing constants.
- One sub-module vga_axis_seq, instantiated twice (horizontal, vertical).
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Inputs: step.
  - Outputs: phase, count, wrap (asserted on the step leaving PH_BP's last count).

Test Plan:
- Release reset with EN=1 -> first edge: X=1, Y=1, SYNC_COLOR=1, both strobes=1. Line 1 has SYNC_COLOR high for exactly 640 clocks, then X=0.
- Measure line 1 timing -> oHS low for exactly 96 clocks, falling at clock 657 after LINE_START (X=640 at clock 640). LINE_START period is 800 clocks.
- Run 2 frames -> FRAME_START period 420000 clocks. oVS low for 1600 clocks starting 490×800 clocks after FRAME_START. Y=0 throughout lines 481..525.
- Drop EN for 37 clocks at X=300,Y=5 -> outputs frozen at X=300, strobes 0. Resume continues at X=301, and that frame's total is 420000 enabled clocks.
- Assert RESET at X=100,Y=200 -> all outputs reset values asynchronously. Release -> next edge X=1,Y=1 with FRAME_START.
- SYNC_POL=1 build -> HS/VS idle low, pulse high with the same widths. With VGA_SYNC_ALIGN_EN, the oHS edge lags by exactly 1 clock versus the non-macro build.
